// File: rtl/rom_tx_sequencer_pkg.sv
// Shared constants and state encoding for the ROM-to-serial sequencer.
// Also used by the bench so both sides agree on widths and ROM count.
package rom_tx_sequencer_pkg;

  localparam int ROM_COUNT = 4;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5
  } state_t;

  // Drop the bit of the ROM that has just been finished from the enable mask.
  function automatic logic [ROM_COUNT-1:0] clear_sel(
    input logic [ROM_COUNT-1:0] mask,
    input logic [SEL_W-1:0]     sel
  );
    logic [ROM_COUNT-1:0] bit_sel;
    bit_sel = {{(ROM_COUNT-1){1'b0}}, 1'b1} << sel;
    return mask & ~bit_sel;
  endfunction

endpackage

// File: rtl/rom_mask_pick.sv
// Picks the next enabled ROM: either the lowest set mask bit, or the lowest
// set bit strictly above the current index. none_o flags an empty choice.
module rom_mask_pick
  import rom_tx_sequencer_pkg::*;
(
  input  logic [ROM_COUNT-1:0] mask_i,
  input  logic [SEL_W-1:0]     cur_i,
  input  logic                 lowest_i,
  output logic [SEL_W-1:0]     idx_o,
  output logic                 none_o
);

  // Scan from the top down so the last qualifying hit is the lowest index.
  always_comb begin
    idx_o  = {SEL_W{1'b0}};
    none_o = 1'b1;
    for (int i = ROM_COUNT - 1; i >= 0; i--) begin
      logic hit_s;
      hit_s  = mask_i[i] && (lowest_i || (SEL_W'(i) > cur_i));
      idx_o  = hit_s ? SEL_W'(i) : idx_o;
      none_o = hit_s ? 1'b0 : none_o;
    end
  end

endmodule

// File: rtl/rom_tx_sequencer.sv
// Streams the enabled ROMs byte by byte into a serial transmitter using a
// start/busy handshake; one FSM owns address, ROM select and tx_start.
module rom_tx_sequencer
  import rom_tx_sequencer_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ACK_TIMEOUT  = 255,
  parameter bit STOP_ON_ZERO = 1'b0
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 write,
  input  logic [ROM_COUNT-1:0] sw,
  input  logic [DATA_W-1:0]    rom1_data,
  input  logic [DATA_W-1:0]    rom2_data,
  input  logic [DATA_W-1:0]    rom3_data,
  input  logic [DATA_W-1:0]    rom4_data,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [SEL_W-1:0]     cur_rom,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]    ACK_LIMIT = (CNT_W + 1)'(ACK_TIMEOUT);

  state_t               state_q;
  logic [ROM_COUNT-1:0] mask_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    tx_data_q;
  logic                 tx_start_q;
  logic [SEL_W-1:0]     cur_rom_q;
  logic                 seq_busy_q;
  logic                 seq_done_q;
  logic                 err_q;
  logic [CNT_W-1:0]     ack_cnt_q;

  logic [DATA_W-1:0]    rom_byte_d;
  logic [ROM_COUNT-1:0] mask_rem_d;
  logic [ROM_COUNT-1:0] pick_mask_s;
  logic                 pick_lowest_s;
  logic [SEL_W-1:0]     pick_idx_s;
  logic                 pick_none_s;
  logic                 end_of_rom_s;
  logic                 ack_expired_s;

  // Byte of the currently selected ROM at the shared address.
  always_comb begin
    case (cur_rom_q)
      2'd0:    rom_byte_d = rom1_data;
      2'd1:    rom_byte_d = rom2_data;
      2'd2:    rom_byte_d = rom3_data;
      2'd3:    rom_byte_d = rom4_data;
      default: rom_byte_d = rom1_data;
    endcase
  end

  assign mask_rem_d = clear_sel(mask_q, cur_rom_q);

  // In IDLE the picker chooses the first ROM from sw; elsewhere the next one.
  always_comb begin
    if (state_q == ST_IDLE) begin
      pick_mask_s   = sw;
      pick_lowest_s = 1'b1;
    end else begin
      pick_mask_s   = mask_rem_d;
      pick_lowest_s = 1'b0;
    end
  end

  rom_mask_pick u_pick (
    .mask_i   (pick_mask_s),
    .cur_i    (cur_rom_q),
    .lowest_i (pick_lowest_s),
    .idx_o    (pick_idx_s),
    .none_o   (pick_none_s)
  );

  assign end_of_rom_s = (addr_q == LAST_ADDR) ||
                        (STOP_ON_ZERO && (tx_data_q == 8'h00));

  // Elapsed wait counts the tx_start cycle and the current cycle.
  assign ack_expired_s = (({1'b0, ack_cnt_q} + 9'd2) >= ACK_LIMIT);

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= {ROM_COUNT{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      tx_data_q  <= {DATA_W{1'b0}};
      tx_start_q <= 1'b0;
      cur_rom_q  <= {SEL_W{1'b0}};
      seq_busy_q <= 1'b0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
      ack_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      tx_start_q <= 1'b0;
      seq_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (write && (sw != 4'b0000)) begin
            mask_q     <= sw;
            cur_rom_q  <= pick_idx_s;
            addr_q     <= {ADDR_W{1'b0}};
            err_q      <= 1'b0;
            seq_busy_q <= 1'b1;
            state_q    <= ST_FETCH;
          end else if (write) begin
            seq_done_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          tx_data_q  <= rom_byte_d;
          tx_start_q <= 1'b1;
          state_q    <= ST_START;
        end
        ST_START: begin
          ack_cnt_q <= {CNT_W{1'b0}};
          state_q   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (ack_expired_s) begin
            err_q      <= 1'b1;
            mask_q     <= {ROM_COUNT{1'b0}};
            seq_busy_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            ack_cnt_q <= ack_cnt_q + 8'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            state_q <= ST_NEXT;
          end else begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_NEXT: begin
          // End-of-ROM is decided before any increment, so addr never wraps.
          if (end_of_rom_s) begin
            mask_q <= mask_rem_d;
            if (pick_none_s) begin
              seq_done_q <= 1'b1;
              seq_busy_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              cur_rom_q <= pick_idx_s;
              addr_q    <= {ADDR_W{1'b0}};
              state_q   <= ST_FETCH;
            end
          end else begin
            addr_q  <= addr_q + 4'd1;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          mask_q     <= {ROM_COUNT{1'b0}};
          seq_busy_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr     = addr_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign cur_rom  = cur_rom_q;
  assign seq_busy = seq_busy_q;
  assign seq_done = seq_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rom_tx_sequencer.sv
// Scoreboard bench: two sequencers (plain, and stop-on-zero) each driven
// into a small transmitter model; a monitor pops expected bytes on tx_start.
module tb_rom_tx_sequencer;
  import rom_tx_sequencer_pkg::*;

  typedef struct packed {
    logic [1:0] rom;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic       rst = 1'b1, write = 1'b0, rst_z = 1'b1, write_z = 1'b0;
  logic [3:0] sw = 4'b0000, sw_z = 4'b0000;
  logic       tx_en = 1'b1;

  logic [3:0] addr, addr_z;
  logic [7:0] tx_data, tx_data_z, r1, r2, r3, r4, z1, z2, z3, z4;
  logic       tx_start, tx_start_z, tx_busy = 1'b0, tx_busy_z = 1'b0;
  logic [1:0] cur_rom, cur_rom_z;
  logic       seq_busy, seq_busy_z, seq_done, seq_done_z, err, err_z;
  int         bcnt = 0, bcnt_z = 0;

  exp_t exp_q[$];
  exp_t exp_z[$];
  int   done_cnt = 0, done_z_cnt = 0;

  // ROM images: rom1 holds 0x00 at address 5, the others never contain 0x00.
  function automatic logic [7:0] rom_byte(input int r, input logic [3:0] a);
    case (r)
      0:       rom_byte = (a == 4'd5) ? 8'h00 : (8'h10 + {4'h0, a});
      1:       rom_byte = 8'h50 + {4'h0, a};
      2:       rom_byte = 8'h90 + {4'h0, a};
      default: rom_byte = 8'hC0 + {4'h0, a};
    endcase
  endfunction

  assign r1 = rom_byte(0, addr);
  assign r2 = rom_byte(1, addr);
  assign r3 = rom_byte(2, addr);
  assign r4 = rom_byte(3, addr);
  assign z1 = rom_byte(0, addr_z);
  assign z2 = rom_byte(1, addr_z);
  assign z3 = rom_byte(2, addr_z);
  assign z4 = rom_byte(3, addr_z);

  rom_tx_sequencer #(.DEPTH(16), .ACK_TIMEOUT(8), .STOP_ON_ZERO(1'b0)) u_dut (
    .sysclk(sysclk), .rst(rst), .write(write), .sw(sw),
    .rom1_data(r1), .rom2_data(r2), .rom3_data(r3), .rom4_data(r4),
    .addr(addr), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .cur_rom(cur_rom), .seq_busy(seq_busy), .seq_done(seq_done), .err(err)
  );

  rom_tx_sequencer #(.DEPTH(16), .ACK_TIMEOUT(255), .STOP_ON_ZERO(1'b1)) u_dut_z (
    .sysclk(sysclk), .rst(rst_z), .write(write_z), .sw(sw_z),
    .rom1_data(z1), .rom2_data(z2), .rom3_data(z3), .rom4_data(z4),
    .addr(addr_z), .tx_data(tx_data_z), .tx_start(tx_start_z), .tx_busy(tx_busy_z),
    .cur_rom(cur_rom_z), .seq_busy(seq_busy_z), .seq_done(seq_done_z), .err(err_z)
  );

  always @(posedge sysclk) cyc <= cyc + 1;

  // Transmitter models: busy for 10 cycles after a sampled tx_start.
  always @(posedge sysclk) begin
    if (tx_start && tx_en) begin
      tx_busy <= 1'b1;
      bcnt    <= 10;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_busy <= 1'b0;
    end
  end

  always @(posedge sysclk) begin
    if (tx_start_z) begin
      tx_busy_z <= 1'b1;
      bcnt_z    <= 10;
    end else if (bcnt_z != 0) begin
      bcnt_z <= bcnt_z - 1;
      if (bcnt_z == 1) tx_busy_z <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitors: compare each presented byte against the scoreboard head.
  always @(negedge sysclk) begin
    exp_t e;
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tx_start", {18'h0, cur_rom, addr, tx_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", {18'h0, cur_rom, addr, tx_data}, {18'h0, e});
      end
    end
    if (seq_done) done_cnt++;
  end

  always @(negedge sysclk) begin
    exp_t e;
    if (tx_start_z) begin
      if (exp_z.size() == 0) begin
        check("unexpected_tx_start_z", {18'h0, cur_rom_z, addr_z, tx_data_z}, 32'hFFFF_FFFF);
      end else begin
        e = exp_z.pop_front();
        check("tx_byte_z", {18'h0, cur_rom_z, addr_z, tx_data_z}, {18'h0, e});
      end
    end
    if (seq_done_z) done_z_cnt++;
  end

  task automatic push_rom(input int r, input int last);
    for (int a = 0; a <= last; a++) begin
      exp_q.push_back('{rom: 2'(r), addr: 4'(a), data: rom_byte(r, 4'(a))});
    end
  endtask

  task automatic pulse_write(input logic [3:0] s);
    @(posedge sysclk);
    #1 sw = s; write = 1'b1;
    @(posedge sysclk);
    #1 write = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    int n = 0;
    while (done_cnt == prev && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    check({name, "_done"}, done_cnt, prev + 1);
    check({name, "_all_bytes"}, exp_q.size(), 0);
    repeat (3) @(negedge sysclk);
    check({name, "_single_done"}, done_cnt, prev + 1);
    check({name, "_idle"}, seq_busy, 1'b0);
  endtask

  initial begin
    int lat, prev, t0, t1, n;

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_addr", addr, 4'h0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_cur_rom", cur_rom, 2'd0);
    check("rst_seq_busy", seq_busy, 1'b0);
    check("rst_seq_done", seq_done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge sysclk);
    #1 rst = 1'b0; rst_z = 1'b0;

    // rom1 only, with first-start latency
    prev = done_cnt;
    push_rom(0, 15);
    pulse_write(4'b0001);
    lat = 0;
    do begin
      @(negedge sysclk);
      lat++;
    end while (!tx_start && lat < 20);
    check("first_start_latency", lat, 2);
    wait_done(prev, "sw0001");

    // rom2 then rom4, with ignored writes and sw changes mid-sequence
    prev = done_cnt;
    push_rom(1, 15);
    push_rom(3, 15);
    pulse_write(4'b1010);
    repeat (40) @(negedge sysclk);
    pulse_write(4'b0100);
    #1 sw = 4'b1111;
    repeat (100) @(negedge sysclk);
    pulse_write(4'b0001);
    wait_done(prev, "sw1010");

    // empty mask: immediate done, no transmission
    prev = done_cnt;
    pulse_write(4'b0000);
    @(negedge sysclk);
    check("sw0000_done_pulse", seq_done, 1'b1);
    check("sw0000_not_busy", seq_busy, 1'b0);
    @(negedge sysclk);
    check("sw0000_done_once", seq_done, 1'b0);
    check("sw0000_done_cnt", done_cnt, prev + 1);

    // ack timeout: transmitter never answers
    tx_en = 1'b0;
    prev = done_cnt;
    push_rom(0, 0);
    pulse_write(4'b0001);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!tx_start && n < 20);
    t0 = cyc;
    n = 0;
    while (!err && n < 400) begin
      @(negedge sysclk);
      n++;
    end
    t1 = cyc;
    check("timeout_err_set", err, 1'b1);
    check("timeout_delay", t1 - t0, 8);
    check("timeout_idle", seq_busy, 1'b0);
    repeat (5) @(negedge sysclk);
    check("timeout_no_done", done_cnt, prev);
    check("timeout_err_sticky", err, 1'b1);

    // next accepted write clears err and runs normally
    tx_en = 1'b1;
    prev = done_cnt;
    push_rom(0, 15);
    pulse_write(4'b0001);
    @(negedge sysclk);
    check("err_cleared_by_write", err, 1'b0);
    wait_done(prev, "after_timeout");

    // reset while waiting for the frame to complete
    push_rom(0, 15);
    pulse_write(4'b0001);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!tx_start && n < 20);
    repeat (4) @(negedge sysclk);
    check("pre_rst_busy", seq_busy, 1'b1);
    exp_q.delete();
    @(posedge sysclk);
    #1 rst = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    check("midrst_addr", addr, 4'h0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_tx_start", tx_start, 1'b0);
    check("midrst_cur_rom", cur_rom, 2'd0);
    check("midrst_seq_busy", seq_busy, 1'b0);
    check("midrst_seq_done", seq_done, 1'b0);
    check("midrst_err", err, 1'b0);
    repeat (3) @(negedge sysclk);
    check("midrst_tx_start_held", tx_start, 1'b0);
    #1 rst = 1'b0;
    repeat (20) @(negedge sysclk);
    check("post_rst_idle", seq_busy, 1'b0);

    // stop-on-zero instance: rom1 0..5 then rom2 0..15
    prev = done_z_cnt;
    for (int a = 0; a <= 5; a++) exp_z.push_back('{rom: 2'd0, addr: 4'(a), data: rom_byte(0, 4'(a))});
    for (int a = 0; a <= 15; a++) exp_z.push_back('{rom: 2'd1, addr: 4'(a), data: rom_byte(1, 4'(a))});
    @(posedge sysclk);
    #1 sw_z = 4'b0011; write_z = 1'b1;
    @(posedge sysclk);
    #1 write_z = 1'b0;
    n = 0;
    while (done_z_cnt == prev && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    check("stop0_done", done_z_cnt, prev + 1);
    check("stop0_all_bytes", exp_z.size(), 0);
    check("stop0_no_err", err_z, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rom_tx_sequencer.md
Name: rom_tx_sequencer

Overview:
Sequencer that streams ROM contents out through the serial transmitter. On a write strobe it latches the switch mask and visits each enabled ROM (rom1..rom4) in ascending index order. For each ROM it walks the addresses, handing one byte at a time to the serial transmitter with a start/busy handshake. It replaces the ad-hoc coupling between the holder, splitter and addr blocks with a single FSM that owns the address, the ROM select and the transmitter start.

Parameters:
DEPTH, 16, entries per ROM; 1..16; last address = DEPTH-1
ACK_TIMEOUT, 255, max cycles waiting for tx_busy to rise after tx_start; 1..255
STOP_ON_ZERO, 0, 1 = a 0x00 byte ends the current ROM after it is sent

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
write  in  1  debounced single-cycle request strobe
sw  in  4  ROM enable mask; bit0=rom1 ... bit3=rom4
rom1_data, rom2_data, rom3_data, rom4_data  in  8 each  combinational ROM outputs for addr
addr  out  4  ROM address, shared by all four ROMs
tx_data  out  8  byte to transmit, registered
tx_start  out  1  one-cycle start pulse to the transmitter
tx_busy  in  1  transmitter busy; high from acceptance until the frame completes
cur_rom  out  2  index of the ROM being streamed
seq_busy  out  1  high whenever state != IDLE
seq_done  out  1  one-cycle pulse when the sequence completes normally
err  out  1  sticky ack-timeout flag; cleared by rst or the next accepted write

Behaviour:
- Clock and reset: one clock, sysclk; rst is synchronous and active-high.
- Reset values: state=IDLE, mask=0, addr=0, tx_data=0, tx_start=0, cur_rom=0, seq_busy=0, seq_done=0, err=0, timeout counter=0.
- Reset mid-operation returns everything to the reset values on the next edge. tx_start is never left asserted.
- States: IDLE, FETCH, START, WAIT_ACK, WAIT_DONE, NEXT.
- IDLE:
  - write=1 and sw!=0: mask<=sw, cur_rom<=lowest set bit of sw, addr<=0, err<=0, go to FETCH.
  - write=1 and sw==0: pulse seq_done the next cycle, stay in IDLE, no transmission.
- FETCH: tx_data <= selected ROM data at addr (mux on cur_rom); go to START.
- START: tx_start=1 for exactly this cycle; timeout counter cleared; go to WAIT_ACK.
- WAIT_ACK:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise the counter increments; reaching ACK_TIMEOUT sets err=1, clears mask, returns to IDLE, no seq_done.
- WAIT_DONE: hold until tx_busy=0, then go to NEXT. No timeout in this state.
- NEXT:
  - End of ROM is addr==DEPTH-1, or STOP_ON_ZERO=1 and tx_data==0x00. At end of ROM, clear mask[cur_rom].
    - Remaining mask !=0: cur_rom <= next higher set bit, addr<=0, go to FETCH.
    - Remaining mask ==0: seq_done=1 for one cycle, go to IDLE.
  - Not end of ROM: addr<=addr+1, go to FETCH.
- Byte timing: per-byte overhead is FETCH+START+NEXT = 3 cycles plus the transmitter time. Latency from write to the first tx_start is 2 cycles.
- Widths and stability:
  - addr never wraps, because the end-of-ROM check precedes the increment.
  - mask is latched, so sw changes during a sequence are ignored.
- write while seq_busy=1 is ignored; there is no queuing.
- tx_busy already high at START (transmitter still finishing): accepted as the ack; the transmitter owns that case.
- A write and a NEXT completion in the same cycle: NEXT has priority and the write is dropped.

Decomposition:
- Shared package, used by this block and its bench:
  - state encoding constants
  - ROM_COUNT=4, ADDR_W=4, DATA_W=8
- Sub-module rom_mask_pick (combinational): input mask[3:0] and current index; output next set index above current (or lowest set index) plus a "none" flag. Reused for the first selection and in NEXT.

Test Plan:
- sw=0001, DEPTH=16, transmitter model with 10-cycle busy -> 16 tx_start pulses, addr 0..15, tx_data equals rom1[0..15], cur_rom=0, then one seq_done pulse; first tx_start 2 cycles after write.
- sw=1010 -> rom2 addr 0..15 then rom4 addr 0..15 (cur_rom 1 then 3), 32 bytes in order, single seq_done after the last frame.
- sw=0000 write -> seq_done pulses next cycle, no tx_start, seq_busy stays 0.
- tx_busy held 0, ACK_TIMEOUT=8 -> err=1 exactly 8 cycles after the tx_start cycle, return to IDLE with no seq_done; next write clears err.
- write pulses mid-sequence, and sw toggled mid-sequence -> ignored; byte count and order unchanged.
- STOP_ON_ZERO=1, rom1[5]=0x00, sw=0011 -> rom1 bytes 0..5 sent, then rom2 from addr 0. Separately, rst asserted during WAIT_DONE -> all outputs at reset values next edge, tx_start stays 0.
